// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches words over a req/ack handshake and
// holds the fetched instruction in EXEC until control lets it retire.
module fetch_unit #(
   parameter int                     INSTR_WIDTH = 32,
   parameter int                     ADDR_WIDTH  = 32,
   parameter logic [ADDR_WIDTH-1:0]  RESET_PC    = 32'h0000_0000,
   parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = 32'h0000_0013
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   stall,
   input  logic                   pc_src,
   input  logic [ADDR_WIDTH-1:0]  pc_target,
   output logic                   imem_req,
   output logic [ADDR_WIDTH-1:0]  imem_addr,
   input  logic                   imem_ack,
   input  logic [INSTR_WIDTH-1:0] imem_rdata,
   output logic [INSTR_WIDTH-1:0] instr,
   output logic                   instr_valid,
   output logic [ADDR_WIDTH-1:0]  pc,
   output logic [ADDR_WIDTH-1:0]  pc_plus4,
   output logic                   misaligned,
   output logic [31:0]            retired_count
);

   typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_t;

   localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

   state_t                  state;
   state_t                  next_state;
   logic                    capture;
   logic                    retire;
   logic [ADDR_WIDTH-1:0]   next_pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // IDLE always lasts one cycle so an ack left over from before reset is never captured
   always_comb begin
      next_state = state;
      capture    = 1'b0;
      retire     = 1'b0;
      next_pc    = pc_plus4;
      case (state)
         IDLE: begin
            next_state = FETCH;
         end
         FETCH: begin
            if (imem_ack) begin
               capture    = 1'b1;
               next_state = EXEC;
            end
         end
         EXEC: begin
            if (!stall) begin
               retire     = 1'b1;
               next_state = FETCH;
               if (pc_src) begin
                  next_pc = {pc_target[ADDR_WIDTH-1:2], 2'b00};
               end
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc            <= RESET_PC;
         instr         <= NOP_INSTR;
         misaligned    <= 1'b0;
         retired_count <= 32'd0;
      end else begin
         misaligned <= retire && pc_src && (pc_target[1:0] != 2'b00);
         if (capture) begin
            instr <= imem_rdata;
         end
         if (retire) begin
            pc            <= next_pc;
            instr         <= NOP_INSTR;
            retired_count <= retired_count + 32'd1;
         end
      end
   end

   assign imem_req    = (state == FETCH);
   assign instr_valid = (state == EXEC);
   assign imem_addr   = pc;
   assign pc_plus4    = pc + PC_STEP;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: handshake timing, branches, stalls,
// reset during a fetch and wrap-around of PC and retire counter.
module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        pc_src;
   logic [31:0] pc_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic        instr_valid;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        misaligned;
   logic [31:0] retired_count;

   int          testCount;
   int          failCount;
   logic [31:0] expInstr;
   logic [31:0] expPc;
   logic [31:0] expCount;

   fetch_unit dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall         (stall),
      .pc_src        (pc_src),
      .pc_target     (pc_target),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .instr         (instr),
      .instr_valid   (instr_valid),
      .pc            (pc),
      .pc_plus4      (pc_plus4),
      .misaligned    (misaligned),
      .retired_count (retired_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Every comparison funnels through here so the counts stay honest
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Inputs change 1 time unit after a rising edge; outputs are checked at the same point
   task automatic applyStimulus(input logic st, input logic src, input logic [31:0] target,
                                input logic ack, input logic [31:0] rdata);
      stall      = st;
      pc_src     = src;
      pc_target  = target;
      imem_ack   = ack;
      imem_rdata = rdata;
      @(posedge clk);
      #1;
   endtask

   // Called while the DUT sits in FETCH; ends with the DUT in EXEC holding word
   task automatic fetchInstr(input logic [31:0] word, input int waits, input logic [31:0] addr,
                             input logic [31:0] addrPlus4);
      for (int i = 0; i < waits; i++) begin
         checkOutput("wait_req", imem_req, 1);
         checkOutput("wait_addr", imem_addr, addr);
         checkOutput("wait_instr", instr, NOP);
         checkOutput("wait_valid", instr_valid, 0);
         applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'hFFFF_FFFF);
      end
      checkOutput("fetch_req", imem_req, 1);
      checkOutput("fetch_addr", imem_addr, addr);
      checkOutput("fetch_valid", instr_valid, 0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, word);
      expInstr = word;
      expPc    = addr;
      checkOutput("exec_instr", instr, word);
      checkOutput("exec_valid", instr_valid, 1);
      checkOutput("exec_pc", pc, addr);
      checkOutput("exec_pc_plus4", pc_plus4, addrPlus4);
      checkOutput("exec_req", imem_req, 0);
   endtask

   // Called while the DUT sits in EXEC; holds stall, then retires and checks the new fetch
   task automatic execInstr(input int stalls, input logic src, input logic [31:0] target,
                            input logic [31:0] nextPc, input logic expMis);
      for (int i = 0; i < stalls; i++) begin
         applyStimulus(1'b1, 1'b1, 32'h0000_0100, 1'b1, 32'hBAAD_F00D);
         checkOutput("stall_instr", instr, expInstr);
         checkOutput("stall_pc", pc, expPc);
         checkOutput("stall_count", retired_count, expCount);
         checkOutput("stall_req", imem_req, 0);
         checkOutput("stall_valid", instr_valid, 1);
      end
      applyStimulus(1'b0, src, target, 1'b0, 32'h0);
      expCount = expCount + 32'd1;
      checkOutput("retire_pc", pc, nextPc);
      checkOutput("retire_addr", imem_addr, nextPc);
      checkOutput("retire_req", imem_req, 1);
      checkOutput("retire_count", retired_count, expCount);
      checkOutput("retire_instr", instr, NOP);
      checkOutput("retire_valid", instr_valid, 0);
      checkOutput("retire_misaligned", misaligned, expMis);
   endtask

   initial begin
      testCount  = 0;
      failCount  = 0;
      expCount   = 32'd0;
      expInstr   = NOP;
      expPc      = 32'h0;
      rst_n      = 1'b0;
      stall      = 1'b0;
      pc_src     = 1'b0;
      pc_target  = 32'h0;
      imem_ack   = 1'b0;
      imem_rdata = 32'h0;

      // Reset values
      @(posedge clk);
      @(posedge clk);
      #1;
      checkOutput("rst_req", imem_req, 0);
      checkOutput("rst_instr", instr, NOP);
      checkOutput("rst_valid", instr_valid, 0);
      checkOutput("rst_pc", pc, 32'h0);
      checkOutput("rst_count", retired_count, 0);
      checkOutput("rst_misaligned", misaligned, 0);
      rst_n = 1'b1;
      checkOutput("idle_req", imem_req, 0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

      // Zero wait states: one instruction every two cycles
      fetchInstr(32'h0050_0093, 0, 32'h0000_0000, 32'h0000_0004);
      execInstr(0, 1'b0, 32'h0, 32'h0000_0004, 1'b0);
      fetchInstr(32'h0010_0113, 0, 32'h0000_0004, 32'h0000_0008);
      execInstr(0, 1'b0, 32'h0, 32'h0000_0008, 1'b0);
      checkOutput("two_retired", retired_count, 2);

      // Three wait states hold request and address
      fetchInstr(32'h0020_81B3, 3, 32'h0000_0008, 32'h0000_000C);
      execInstr(0, 1'b0, 32'h0, 32'h0000_000C, 1'b0);
      fetchInstr(32'h0000_0033, 1, 32'h0000_000C, 32'h0000_0010);
      execInstr(0, 1'b0, 32'h0, 32'h0000_0010, 1'b0);

      // Taken branches, aligned then misaligned
      fetchInstr(32'h0300_006F, 0, 32'h0000_0010, 32'h0000_0014);
      execInstr(0, 1'b1, 32'h0000_0040, 32'h0000_0040, 1'b0);
      fetchInstr(32'h0000_0067, 0, 32'h0000_0040, 32'h0000_0044);
      execInstr(0, 1'b1, 32'h0000_0042, 32'h0000_0040, 1'b1);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("misaligned_pulse_end", misaligned, 0);
      checkOutput("misaligned_addr_hold", imem_addr, 32'h0000_0040);

      // Five stall cycles with stray acks, then continue at pc+4
      fetchInstr(32'h0040_0213, 0, 32'h0000_0040, 32'h0000_0044);
      execInstr(5, 1'b0, 32'h0, 32'h0000_0044, 1'b0);

      // PC wraps from the top of the address space, counter wraps from all-ones
      fetchInstr(32'h0000_0013, 0, 32'h0000_0044, 32'h0000_0048);
      execInstr(0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0);
      fetchInstr(32'h0010_0093, 0, 32'hFFFF_FFFC, 32'h0000_0000);
      force dut.retired_count = 32'hFFFF_FFFF;
      #1;
      release dut.retired_count;
      expCount = 32'hFFFF_FFFF;
      checkOutput("preset_count", retired_count, 32'hFFFF_FFFF);
      execInstr(0, 1'b0, 32'h0, 32'h0000_0000, 1'b0);
      checkOutput("count_wrapped", retired_count, 0);

      // Reset in the middle of a fetch with acks during reset and IDLE
      rst_n      = 1'b0;
      imem_ack   = 1'b1;
      imem_rdata = 32'hBAD0_0BAD;
      #1;
      checkOutput("midrst_req", imem_req, 0);
      checkOutput("midrst_instr", instr, NOP);
      checkOutput("midrst_count", retired_count, 0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'hBAD0_0BAD);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'hBAD0_0BAD);
      rst_n = 1'b1;
      checkOutput("postrst_idle_req", imem_req, 0);
      checkOutput("postrst_idle_valid", instr_valid, 0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("postrst_instr", instr, NOP);
      checkOutput("postrst_count", retired_count, 0);
      checkOutput("postrst_valid", instr_valid, 0);
      expCount = 32'd0;
      fetchInstr(32'h0050_0093, 0, 32'h0000_0000, 32'h0000_0004);
      execInstr(0, 1'b0, 32'h0, 32'h0000_0004, 1'b0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
